// File: rtl/alu_result_if.sv
// Handshake bundle between execute, the ALU result stage, and writeback.
// The master side feeds results in and consumes them; the slave side is the stage.
interface alu_result_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_rd;
    logic [3:0]  in_op;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_rd;

    modport master (
        output in_valid, in_result, in_rd, in_op, in_ovf, out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_result, in_rd, in_op, in_ovf, out_ready,
        output in_ready, out_valid, out_result, out_rd
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry result FIFO between execute and writeback.
// Also maintains the architectural {Z, V, N} flags, which are updated when an entry is pushed.
module alu_result_stage (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_if.slave      bus,
    input  logic             flush,
    output logic [2:0]       flags,
    output logic [1:0]       count
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic [15:0] entry_result_reg [2];
    logic [3:0]  entry_rd_reg     [2];

    logic [1:0] count_reg,  count_next;
    logic       rd_ptr_reg, rd_ptr_next;
    logic       wr_ptr_reg, wr_ptr_next;
    logic [2:0] flags_reg,  flags_next;

    logic push;
    logic pop;

    // No bypass: in_ready depends only on occupancy, so a full stage stalls even if writeback drains.
    assign bus.in_ready   = (count_reg != 2'd2);
    assign bus.out_valid  = (count_reg != 2'd0);
    assign bus.out_result = entry_result_reg[rd_ptr_reg];
    assign bus.out_rd     = entry_rd_reg[rd_ptr_reg];
    assign flags          = flags_reg;
    assign count          = count_reg;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg ^ pop;
        wr_ptr_next = wr_ptr_reg ^ push;
        flags_next  = flags_reg;

        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase

        if (push) begin
            case (bus.in_op)
                OP_ADD, OP_SUB: begin
                    flags_next[2] = (bus.in_result == 16'h0000);
                    flags_next[1] = bus.in_ovf;
                    flags_next[0] = bus.in_result[15];
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    flags_next[2] = (bus.in_result == 16'h0000);
                end
                default: flags_next = flags_reg;
            endcase
        end

        // Flush wins over push and pop alike; flags set by older entries are kept.
        if (flush) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
            flags_next  = flags_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            flags_reg  <= 3'b000;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            flags_reg  <= flags_next;
        end
    end

    // Data storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entry_result_reg[wr_ptr_reg] <= bus.in_result;
            entry_rd_reg[wr_ptr_reg]     <= bus.in_rd;
        end
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, asynchronous, active-low.
REQ-003: in_valid  input  1  execute stage presents a result this cycle.
REQ-004: in_ready  output  1  stage can accept a result this cycle.
REQ-005: in_result  input  16  ALU/shifter result (value destined for rd).
REQ-006: in_rd  input  4  destination register index.
REQ-007: in_op  input  4  instruction opcode that produced in_result.
REQ-008: in_ovf  input  1  signed overflow from the adder, meaningful only for ADD/SUB.
REQ-009: flush  input  1  discard all buffered results.
REQ-010: out_valid  output  1  buffered result available to writeback.
REQ-011: out_ready  input  1  writeback accepts the result this cycle.
REQ-012: out_result  output  16  head-entry result.
REQ-013: out_rd  output  4  head-entry destination index.
REQ-014: flags  output  3  architectural flags {Z, V, N}, bit 2 = Z.
REQ-015: count  output  2  number of buffered entries, 0..2.

Function
REQ-016: Storage SHALL be a 2-entry FIFO of {result[15:0], rd[3:0]}, with a 1-bit read pointer, a 1-bit write pointer and the 2-bit count.
REQ-017: Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018: in_ready SHALL be combinational: 1 when count < 2, else 0; there is no pass-through when full, even if out_ready = 1.
REQ-019: out_valid SHALL be 1 when count > 0; out_result/out_rd SHALL be driven from the read-pointer entry and are don't-care when count = 0.
REQ-020: Latency SHALL be exactly 1 cycle: an entry pushed at edge N is visible on out_* after edge N; there is no combinational in->out bypass.
REQ-021: Simultaneous push and pop with count = 1 SHALL leave count = 1 and advance both pointers; ordering is strict FIFO.
REQ-022: Pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow below 0.
REQ-023: flags SHALL update at the push edge, not at the pop edge, from in_result and in_op.
REQ-024: in_op 0000 (ADD) or 0001 (SUB): Z <= (in_result == 0), N <= in_result[15], V <= in_ovf.
REQ-025: in_op 0010 (XOR), 0100 (SLL), 0101 (SRA) or 0110 (ROR): Z <= (in_result == 0); N and V hold.
REQ-026: Any other in_op SHALL be pushed normally and SHALL leave all flags unchanged.
REQ-027: An entry with in_rd = 0 SHALL be buffered and emitted like any other; suppressing writes to register 0 is the job of writeback.
REQ-028: flush = 1 SHALL, at that edge, set count = 0 and both pointers to 0.
REQ-029: A flush edge SHALL take priority over a push or pop at the same edge: the pushed entry is dropped and flags are not updated by it.
REQ-030: A flush SHALL NOT restore flag values set by entries pushed earlier.
REQ-031: in_ready SHALL be evaluated normally during a flush cycle; the flush does not gate it.

Reset
REQ-032: While rst_n = 0: count = 0, pointers = 0, flags = 000, out_valid = 0, in_ready = 1.
REQ-033: Reset assertion mid-operation SHALL clear the state immediately (asynchronously); buffered entries are lost.
REQ-034: After rst_n deasserts, the first push SHALL be accepted on the first rising edge.
REQ-035: Storage data registers need not be reset.

Verification
REQ-036: Single push: ADD, result 0x0000, ovf 1, rd 3, out_ready = 0 -> next cycle out_valid = 1, out_result = 0x0000, out_rd = 3, flags = 110, count = 1.
REQ-037: Fill to full: push SLL 0x8000 rd 1, then SUB 0xFFFE rd 2 with ovf 0, out_ready = 0 -> count = 2, in_ready = 0, flags = 001; a third push is not accepted.
REQ-038: Drain with concurrent push: at count = 1, push XOR 0x0000 and pop at the same edge -> count stays 1, the popped entry is the older one, Z = 1, N and V unchanged.
REQ-039: Non-flag op: push opcode 0111 result 0x0000 with flags = 001 -> flags stay 001 and the entry is emitted.
REQ-040: Flush with push: count = 2 and flush = 1 with in_valid = 1 for ADD 0x0000 -> next cycle count = 0, out_valid = 0, flags unchanged.
REQ-041: Async reset: pull rst_n low between clock edges with count = 2 -> out_valid = 0 and flags = 000 before the next edge.
